// File: rtl/fifo_rd_stream.sv
// Read-side FIFO consumer: issues rd_rq against the async FIFO and re-times the
// one-cycle read latency through a 2-entry buffer into a first-word-fall-through stream.

module fifo_rd_stream_chk (
  input logic       clk,
  input logic       rst,
  input logic [1:0] occ,
  input logic       inflight,
  input logic       pop
);

  // Buffered words plus the returning word must always fit in the two entries.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (({1'b0, occ} + {2'b00, inflight}) <= 3'd2));

  // Downstream can only accept a word that is actually buffered.
  a_no_empty_pop: assert property (@(posedge clk) disable iff (rst)
    !(pop && (occ == 2'd0)));

endmodule

module fifo_rd_stream #(
  parameter int WIDTH = 8
) (
  input  logic             r_clk,
  input  logic             rst,
  input  logic             empty,
  input  logic [WIDTH-1:0] rdata,
  output logic             rd_rq,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic [1:0]       occ_r, occ_s;
  logic             inflight_r, inflight_s;
  logic [WIDTH-1:0] data0_r, data0_s;
  logic [WIDTH-1:0] data1_r, data1_s;
  logic             pop_s;
  logic [2:0]       level_s;
  logic [1:0]       wr_idx_s;

  // Handshake terms; the level bound leaves a free entry for every returning word.
  always_comb begin
    pop_s    = (occ_r != 2'd0) & out_ready;
    level_s  = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    wr_idx_s = occ_r - {1'b0, pop_s};
    rd_rq    = ~empty & ~flush & ~rst & (level_s <= 3'd1);
  end

  // Next-state: shift on pop from a full buffer, land the returning word behind the survivors.
  always_comb begin
    occ_s      = occ_r;
    inflight_s = inflight_r;
    data0_s    = data0_r;
    data1_s    = data1_r;
    if (flush) begin
      occ_s      = 2'd0;
      inflight_s = 1'b0;
    end else begin
      occ_s      = level_s[1:0];
      inflight_s = rd_rq;
      if (pop_s && (occ_r == 2'd2)) begin
        data0_s = data1_r;
      end else begin
        data0_s = data0_r;
      end
      if (inflight_r) begin
        if (wr_idx_s == 2'd0) begin
          data0_s = rdata;
        end else begin
          data1_s = rdata;
        end
      end else begin
        data1_s = data1_r;
      end
    end
  end

  // State registers.
  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) begin
      occ_r      <= 2'd0;
      inflight_r <= 1'b0;
      data0_r    <= '0;
      data1_r    <= '0;
    end else begin
      occ_r      <= occ_s;
      inflight_r <= inflight_s;
      data0_r    <= data0_s;
      data1_r    <= data1_s;
    end
  end

  assign out_valid = (occ_r != 2'd0);
  assign out_data  = data0_r;
  assign occupancy = occ_r;

  fifo_rd_stream_chk u_chk (
    .clk      (r_clk),
    .rst      (rst),
    .occ      (occ_r),
    .inflight (inflight_r),
    .pop      (pop_s)
  );

endmodule
